// File: rtl/pilha_param.sv
`default_nettype none
// ============================================================================
//  Module   : pilha_param
//  Brief    : Parametrised LIFO operand stack. Pushes from the control unit
//             or the ALU, pops to a registered output, single-cycle
//             replace-top, full/empty status and sticky overflow/underflow.
//  Revision : 1.0 - initial release
// ============================================================================
module pilha_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              src_sel,
    input  logic [DATA_W-1:0] din_uc,
    input  logic [DATA_W-1:0] din_ula,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W-1:0]  tos,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    // Index width of the storage array; DEPTH >= 2 keeps this at least 1.
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] c_full_level = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_one        = PTR_W'(1);

    // Storage is deliberately left unreset; entries at or above sp are dead.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  sp_q,         sp_d;
    logic [DATA_W-1:0] dout_q,       dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q,   overflow_d;
    logic              underflow_q,  underflow_d;

    logic [DATA_W-1:0] w_din;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_sp_idx;
    logic [IDX_W-1:0]  w_wr_idx;

    // Request decode: source mux, status and which halves of a request are accepted.
    always_comb begin
        w_din     = src_sel ? din_ula : din_uc;
        w_empty   = (sp_q == '0);
        w_full    = (sp_q == c_full_level);
        // Index arithmetic is only used when the matching entry exists,
        // so the truncation never discards a meaningful bit.
        w_top_idx = IDX_W'(sp_q - c_one);
        w_sp_idx  = IDX_W'(sp_q);
        w_pop_ok  = pop && !w_empty;
        // A push into a full stack is still fine when paired with a valid pop
        // (replace-top); a push into an empty stack always has room.
        w_push_ok = push && (!w_full || w_pop_ok);
        w_ovf_set = push && !w_push_ok;
        w_unf_set = pop && w_empty;
        // Replace-top overwrites the current top; a plain push fills slot sp.
        w_wr_idx  = w_pop_ok ? w_top_idx : w_sp_idx;
    end

    // Next-state for pointer, output register and sticky error flags.
    always_comb begin
        sp_d         = sp_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        case ({w_push_ok, w_pop_ok})
            2'b10:   sp_d = sp_q + c_one;
            2'b01:   sp_d = sp_q - c_one;
            default: sp_d = sp_q;
        endcase

        if (w_pop_ok) begin
            dout_d       = mem_q[w_top_idx];
            dout_valid_d = 1'b1;
        end

        // A fresh error in the clearing cycle wins over the clear.
        overflow_d  = (overflow_q  && !clr_err) || w_ovf_set;
        underflow_d = (underflow_q && !clr_err) || w_unf_set;
    end

    // Control state register; reset discards any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            sp_q         <= sp_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage write port; suppressed during reset so a discarded push leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            mem_q[w_wr_idx] <= w_din;
        end
    end

    // Output mapping; top is gated by empty so stale memory is never visible.
    always_comb begin
        dout       = dout_q;
        dout_valid = dout_valid_q;
        top        = w_empty ? '0 : mem_q[w_top_idx];
        tos        = sp_q;
        empty      = w_empty;
        full       = w_full;
        overflow   = overflow_q;
        underflow  = underflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pilha_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pilha_param
//  Brief    : Self-checking bench for pilha_param (DEPTH=4, DATA_W=16).
//             A queue-based reference model is compared every cycle, plus
//             hand-computed literal expectations for the directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pilha_param;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              src_sel = 1'b0;
    logic [DATA_W-1:0] din_uc = '0;
    logic [DATA_W-1:0] din_ula = '0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [DATA_W-1:0] top;
    logic [PTR_W-1:0]  tos;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    pilha_param #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .src_sel    (src_sel),
        .din_uc     (din_uc),
        .din_ula    (din_ula),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .top        (top),
        .tos        (tos),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_total  = 0;
    int n_passed = 0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_dout  = '0;
    logic              m_dv    = 1'b0;
    logic              m_ovf   = 1'b0;
    logic              m_unf   = 1'b0;
    logic              m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Apply one clock cycle of stimulus and advance the model by the same edge.
    task automatic cyc(input logic r, input logic ps, input logic pp, input logic sel,
                       input logic [DATA_W-1:0] uc, input logic [DATA_W-1:0] ula,
                       input logic clr);
        logic [DATA_W-1:0] din;
        logic e, f, os, us;
        rst = r; push = ps; pop = pp; src_sel = sel;
        din_uc = uc; din_ula = ula; clr_err = clr;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            din = sel ? ula : uc;
            e = (m_q.size() == 0);
            f = (m_q.size() == DEPTH);
            os = 1'b0; us = 1'b0; m_dv = 1'b0;
            if (ps && pp) begin
                if (!e) begin
                    m_dout = m_q[$];
                    m_q[m_q.size()-1] = din;
                    m_dv = 1'b1;
                end else begin
                    us = 1'b1;
                    m_q.push_back(din);
                end
            end else if (ps) begin
                if (f) os = 1'b1;
                else   m_q.push_back(din);
            end else if (pp) begin
                if (e) us = 1'b1;
                else begin
                    m_dout = m_q.pop_back();
                    m_dv = 1'b1;
                end
            end
            m_ovf = (m_ovf && !clr) || os;
            m_unf = (m_unf && !clr) || us;
        end
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_tos",        32'(tos),        32'(m_q.size()));
                chk("m_empty",      32'(empty),      32'(m_q.size() == 0));
                chk("m_full",       32'(full),       32'(m_q.size() == DEPTH));
                chk("m_top",        32'(top),        (m_q.size() != 0) ? 32'(m_q[$]) : 32'd0);
                chk("m_dout",       32'(dout),       32'(m_dout));
                chk("m_dout_valid", 32'(dout_valid), 32'(m_dv));
                chk("m_overflow",   32'(overflow),   32'(m_ovf));
                chk("m_underflow",  32'(underflow),  32'(m_unf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        cyc(1, 0, 0, 0, 16'h0, 16'h0, 0);
        cyc(1, 0, 0, 0, 16'h0, 16'h0, 0);
        m_valid = 1'b1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_tos", 32'(tos), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_flags", 32'({overflow, underflow, dout_valid}), 32'h0);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0);

        // Fill from both sources
        cyc(0, 1, 0, 0, 16'h1111, 16'hBEEF, 0);
        cyc(0, 1, 0, 1, 16'hDEAD, 16'h2222, 0);
        cyc(0, 1, 0, 0, 16'h3333, 16'h0, 0);
        cyc(0, 1, 0, 1, 16'h0, 16'h4444, 0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_tos", 32'(tos), 32'h4);
        chk("fill_top", 32'(top), 32'h4444);

        // Overflow
        cyc(0, 1, 0, 0, 16'h5555, 16'h0, 0);
        chk("ovf_tos", 32'(tos), 32'h4);
        chk("ovf_top", 32'(top), 32'h4444);
        chk("ovf_flag", 32'(overflow), 32'h1);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("ovf_clr", 32'(overflow), 32'h0);

        // Drain
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("pop0", 32'({dout_valid, dout}), 32'h1_4444);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("pop1", 32'({dout_valid, dout}), 32'h1_3333);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("pop2", 32'({dout_valid, dout}), 32'h1_2222);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("pop3", 32'({dout_valid, dout}), 32'h1_1111);
        chk("drain_empty", 32'(empty), 32'h1);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0);
        chk("dv_strobe", 32'({dout_valid, dout}), 32'h0_1111);

        // Underflow
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("unf_dout", 32'({dout_valid, dout}), 32'h0_1111);
        chk("unf_flag", 32'(underflow), 32'h1);
        chk("unf_tos", 32'(tos), 32'h0);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 1);
        chk("unf_clr_race", 32'(underflow), 32'h1);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 1);
        chk("unf_clr", 32'(underflow), 32'h0);

        // Replace-top
        cyc(0, 1, 0, 0, 16'h000A, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h000B, 16'h0, 0);
        cyc(0, 1, 1, 1, 16'h0, 16'h000C, 0);
        chk("rep_dout", 32'({dout_valid, dout}), 32'h1_000B);
        chk("rep_tos", 32'(tos), 32'h2);
        chk("rep_top", 32'(top), 32'h000C);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("rep_pop_c", 32'(dout), 32'h000C);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("rep_pop_a", 32'(dout), 32'h000A);

        // Push+pop on empty
        cyc(0, 1, 1, 0, 16'h0077, 16'h0, 0);
        chk("ep_unf", 32'(underflow), 32'h1);
        chk("ep_dv", 32'(dout_valid), 32'h0);
        chk("ep_tos", 32'(tos), 32'h1);
        chk("ep_top", 32'(top), 32'h0077);
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 1);

        // Replace-top while full: no overflow
        cyc(0, 1, 0, 0, 16'h0088, 16'h0, 0);
        cyc(0, 1, 0, 0, 16'h0099, 16'h0, 0);
        cyc(0, 1, 0, 1, 16'h0, 16'h00AA, 0);
        cyc(0, 1, 1, 0, 16'h00BB, 16'h0, 0);
        chk("fr_dout", 32'(dout), 32'h00AA);
        chk("fr_ovf", 32'(overflow), 32'h0);
        chk("fr_top", 32'(top), 32'h00BB);
        chk("fr_tos", 32'(tos), 32'h4);

        // Reset mid-operation with a concurrent push
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        cyc(1, 1, 0, 0, 16'h1234, 16'h0, 0);
        chk("mrst_tos", 32'(tos), 32'h0);
        chk("mrst_empty", 32'(empty), 32'h1);
        chk("mrst_top", 32'(top), 32'h0);
        cyc(0, 0, 1, 0, 16'h0, 16'h0, 0);
        chk("mrst_unf", 32'(underflow), 32'h1);
        chk("mrst_dout", 32'(dout), 32'h0);

        // Short back-to-back traffic with no bubbles
        for (int i = 0; i < 12; i++) begin
            cyc(0, (i % 3) != 2, (i % 2) == 1, i[0], 16'(16'h0100 + i), 16'(16'h0200 + i), 0);
        end
        cyc(0, 0, 0, 0, 16'h0, 16'h0, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pilha_param.md
# pilha_param

Parametrised LIFO stack, the next generation of the processor's operand stack. It pushes words from either the control unit (UC) or the ALU (ULA) and pops them to a registered output. It reports full/empty, sticky overflow/underflow errors, and supports a single-cycle replace-top (push+pop). It sits between the UC/ULA datapath and the operand bus; depth and word width are set per instance.

## Interface
Parameters:
- DATA_W, 16, stored word width.
- DEPTH, 16, number of entries; any value ≥ 2, not required to be a power of two.
- PTR_W, $clog2(DEPTH+1), width of the stack pointer; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- push  in  1  write request.
- pop  in  1  read request.
- src_sel  in  1  push source: 0 selects din_uc, 1 selects din_ula.
- din_uc  in  DATA_W  push data from control unit.
- din_ula  in  DATA_W  push data from ALU.
- clr_err  in  1  clears sticky error flags.
- dout  out  DATA_W  registered popped word.
- dout_valid  out  1  one-cycle strobe: dout was updated by a successful pop.
- top  out  DATA_W  combinational peek of mem[sp-1]; 0 when empty.
- tos  out  PTR_W  current stack pointer sp = number of stored entries.
- empty  out  1  sp == 0, combinational from sp.
- full  out  1  sp == DEPTH, combinational from sp.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

## Operation
- Storage: DEPTH × DATA_W register array. Memory is not reset; contents above sp are don't-care.
- din = src_sel ? din_ula : din_uc, sampled in the cycle of the request.
- Idle (push=0, pop=0): all state holds; dout holds; dout_valid=0.
- Push only:
  - If !full: mem[sp] ← din, sp ← sp+1.
  - If full: no write, sp holds, overflow ← 1.
- Pop only:
  - If !empty: dout ← mem[sp-1], dout_valid ← 1, sp ← sp-1.
  - If empty: dout holds, dout_valid ← 0, sp holds, underflow ← 1.
- Push and pop together:
  - If !empty (including full): replace-top. dout ← old mem[sp-1], mem[sp-1] ← din, sp unchanged, dout_valid ← 1, no error.
  - If empty: the pop is rejected (underflow ← 1, dout_valid ← 0). The push proceeds normally (mem[0] ← din, sp ← 1).
- Error flags:
  - overflow and underflow stay set until clr_err or rst.
  - clr_err clears both flags. If a new error occurs in the same cycle as clr_err, the flag ends set.
- sp never leaves the range 0..DEPTH; there is no wrap-around under any input sequence.

## Timing
- Reset values (rst high at an edge): sp=0, dout=0, dout_valid=0, overflow=0, underflow=0. As a result tos=0, empty=1, full=0, top=0.
- rst has priority over push/pop/clr_err in the same cycle; a request in that cycle is discarded. A reset mid-sequence empties the stack logically; the old memory contents are never visible through top or dout afterward.
- Pop latency: 1 cycle. A request at edge N gives dout/dout_valid valid after edge N and held until edge N+1.
- Push-to-top: a word pushed at edge N appears on top after edge N, combinationally from the updated sp and memory.
- tos, empty and full reflect the new sp immediately after the edge.
- Back-to-back push/pop every cycle is supported with no bubbles; there is no handshake stall.

## Test plan
- Reset and idle (DEPTH=4, DATA_W=16): assert rst for 2 cycles -> dout=0, tos=0, empty=1, full=0, overflow=0, underflow=0, dout_valid=0.
- Fill and drain:
  - Push 0x1111 (src_sel=0), then 0x2222 (src_sel=1, din_uc=0xDEAD), then 0x3333, then 0x4444 -> full=1, tos=4, top=0x4444.
  - Pop 4 times -> dout sequence 0x4444, 0x3333, 0x2222, 0x1111, each with dout_valid=1; then empty=1.
- Overflow: with the stack full, push 0x5555 -> tos stays 4, top=0x4444, overflow=1 and stays set. Pulse clr_err -> overflow=0.
- Underflow: on an empty stack, pop -> dout keeps its last value, dout_valid=0, underflow=1, tos=0. Then clr_err together with another empty pop -> underflow stays 1.
- Replace-top:
  - Stack holds [0x0A, 0x0B]; push+pop with din_ula=0x0C, src_sel=1 -> dout=0x0B, dout_valid=1, tos=2, top=0x0C.
  - On an empty stack, push+pop of 0x77 -> underflow=1, dout_valid=0, tos=1, top=0x77.
- Reset mid-operation: push 3 words, then assert rst together with push -> tos=0, empty=1, top=0. The next pop gives underflow=1 and dout=0.
